score_digit_renderer: RTL and testbench
=======================================

# score_digit_renderer

Reads the number-glyph sprite ROM (ten 25×25 glyphs, digits 0–9, 625 words each, 24-bit RGB, one-cycle registered read) to draw a five-digit decimal score on the VGA raster. Accepts a 16-bit binary score, converts it to BCD with a sequential double-dabble engine, and double-buffers the digits so the display never tears mid-frame. Sits between game logic and the colour mapper, driving one read port of the glyph ROM.

## Interface
- X0, 10'd480, left pixel column of the digit field
- Y0, 10'd32, top pixel row of the digit field
- BLANK_LEADING, 1, suppress leading zeros (units digit always drawn)
- KEY_COLOR, 24'hFF00FF, transparent colour in glyph data
- Clk  in  1  system clock
- Reset_n  in  1  asynchronous, active-low reset
- score  in  16  binary score, sampled on score_load
- score_load  in  1  single-cycle request to convert score
- frame_start  in  1  single-cycle pulse at start of vertical blank
- DrawX  in  10  current raster column
- DrawY  in  10  current raster row
- rom_data  in  24  glyph ROM read data, valid one cycle after rom_addr
- rom_addr  out  13  glyph ROM read address
- busy  out  1  conversion in progress
- pixel_on  out  1  pixel_rgb valid and opaque this cycle
- pixel_rgb  out  24  glyph colour

## Operation
- Converter FSM states: IDLE, SHIFT, DONE.
  - IDLE: on score_load, capture score into shift register, clear BCD accumulator, counter ← 0, go SHIFT.
  - SHIFT: per cycle, add 3 to every BCD nibble ≥ 5, then shift {bcd,bin} left one bit; after the 16th shift go DONE.
  - DONE: write the five nibbles to pending[4:0], set pending_valid, go IDLE.
- score_load while busy: value captured into a one-deep request register; serviced immediately after DONE. A second load while a request is queued overwrites it (latest wins).
- Display digits shown[4:0] update from pending only on frame_start when pending_valid; pending_valid then clears. pending_valid set and frame_start in same cycle as DONE: the new value is copied this frame.
- Digit field: 125×25 pixels, digit k (k=0 most significant) spans X0+25k … X0+25k+24. Column index via five comparators against constant boundaries, no divider.
- Address = shown[k]*625 + (DrawY−Y0)*25 + (DrawX−X0−25k); all arithmetic 13 bits, max 6249.
- Outside the field, rom_addr holds 0 and pixel_on is 0.
- Blanking: with BLANK_LEADING=1, digit k is blank if it and all more-significant digits are 0 and k<4.
- pixel_on = in-field & not blanked & rom_data ≠ KEY_COLOR.

## Timing
- Reset values: rom_addr 0, pixel_on 0, pixel_rgb 0, busy 0, shown all 0, pending_valid 0, FSM IDLE, request queue empty.
- Conversion: busy high cycle after score_load, 16 SHIFT cycles + 1 DONE; busy low cycle 19 after load (load = cycle 0).
- Pixel pipeline: DrawX/DrawY at cycle n → rom_addr registered at n+1 → rom_data at n+2 → pixel_on/pixel_rgb registered at n+3. In-field and blank flags travel alongside in a matching delay line.
- Reset mid-conversion: FSM aborts to IDLE, queued request dropped, shown cleared; display reads zeros (single "0" with blanking).
- score_load and frame_start same cycle: frame_start acts on previous pending only.

## Structure
- Shared package (sprite_pkg): GLYPH_W=25, GLYPH_H=25, GLYPH_WORDS=625, ROM_DEPTH=6250, typedef bcd_t (logic [3:0]), typedef rgb_t (logic [23:0]), KEY_COLOR default.
- One sub-module: bin2bcd_seq (16-bit sequential double-dabble, start/busy/done, five BCD nibbles out); renderer holds buffering and pixel pipeline.

## Test plan
- Reset, no load: DrawX=X0+100, DrawY=Y0+12 → rom_addr = 0*625+12*25+0 = 300 at n+1; digits 0–3 blank, pixel_on 0 for k<4.
- Load 12345 → busy 18 cycles, pending 1,2,3,4,5; shown unchanged until frame_start, then DrawX=X0+26, DrawY=Y0+1 → rom_addr 2*625+25+1=1276.
- Load 65535 → digits 6,5,5,3,5; load 0 → only units digit drawn with blanking.
- Load 100 then 200 while busy, then 300 while still busy → final shown after frame_start = 300; 200 never displayed.
- ROM model returns KEY_COLOR at chosen address → pixel_on 0 exactly at n+3; opaque colour 24'h112233 → pixel_rgb 24'h112233, pixel_on 1.
- Assert Reset_n low at SHIFT cycle 8 → busy 0, all outputs reset asynchronously; next load converts correctly.

Source files
------------

// File: rtl/sprite_pkg.sv
// Shared glyph-ROM geometry, pixel/digit types and the glyph base-address helper.
package sprite_pkg;

  localparam int GLYPH_W     = 25;
  localparam int GLYPH_H     = 25;
  localparam int GLYPH_WORDS = 625;
  localparam int ROM_DEPTH   = 6250;
  localparam int NUM_DIGITS  = 5;

  typedef logic [3:0]  bcd_t;
  typedef logic [23:0] rgb_t;

  localparam rgb_t KEY_COLOR_DEFAULT = 24'hFF00FF;

  // First ROM word of a glyph; a constant multiply, so it maps to shifts and adds.
  function automatic logic [12:0] glyph_base(input bcd_t digit);
    return 13'(digit) * 13'(GLYPH_WORDS);
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential 16-bit double-dabble converter: one shift per cycle, five BCD nibbles out.
// A start seen in DONE restarts straight into SHIFT, so a queued request loses no cycle.
module bin2bcd_seq
  import sprite_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [15:0]           bin_in,
  output logic                  busy,
  output logic                  done,
  output bcd_t [NUM_DIGITS-1:0] digits
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t                  state;
  logic [15:0]             bin_sr;
  logic [4*NUM_DIGITS-1:0] bcd_sr;
  logic [4*NUM_DIGITS-1:0] bcd_adj;
  logic [3:0]              shift_cnt;

  // Add 3 to every nibble of 5 or more so the following shift carries correctly into the next decade.
  always_comb begin
    bcd_adj = bcd_sr;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (bcd_sr[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_sr[4*i +: 4] + 4'd3;
    end
  end

  // Top nibble of the accumulator is the most significant digit, presented as digits[0].
  always_comb begin
    digits = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      digits[k] = bcd_sr[4*(NUM_DIGITS-1-k) +: 4];
    end
  end

  // Converter FSM: load, sixteen adjust-and-shift steps, then one DONE cycle holding the result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      bin_sr    <= '0;
      bcd_sr    <= '0;
      shift_cnt <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            bin_sr    <= bin_in;
            bcd_sr    <= '0;
            shift_cnt <= '0;
            state     <= SHIFT;
          end else begin
            state <= IDLE;
          end
        end
        SHIFT: begin
          {bcd_sr, bin_sr} <= {bcd_adj[4*NUM_DIGITS-2:0], bin_sr, 1'b0};
          shift_cnt        <= shift_cnt + 4'd1;
          if (shift_cnt == 4'd15) state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule

// File: rtl/score_digit_renderer.sv
// Five-digit score overlay: queues score loads, converts to BCD, swaps digits at frame start
// and streams glyph ROM addresses/pixels through a three-stage pipeline.
module score_digit_renderer
  import sprite_pkg::*;
#(
  parameter logic [9:0] X0            = 10'd480,
  parameter logic [9:0] Y0            = 10'd32,
  parameter bit         BLANK_LEADING = 1'b1,
  parameter rgb_t       KEY_COLOR     = KEY_COLOR_DEFAULT
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic [15:0] score,
  input  logic        score_load,
  input  logic        frame_start,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  input  rgb_t        rom_data,
  output logic [12:0] rom_addr,
  output logic        busy,
  output logic        pixel_on,
  output rgb_t        pixel_rgb
);

  localparam int          ADDR_W = $clog2(ROM_DEPTH);
  localparam logic [10:0] X_BASE = {1'b0, X0};
  localparam logic [10:0] Y_BASE = {1'b0, Y0};
  localparam logic [10:0] X_END  = X_BASE + 11'(NUM_DIGITS * GLYPH_W);
  localparam logic [10:0] Y_END  = Y_BASE + 11'(GLYPH_H);

  logic                  conv_start;
  logic                  conv_busy;
  logic                  conv_done;
  logic                  conv_accept;
  logic [15:0]           conv_value;
  bcd_t [NUM_DIGITS-1:0] conv_digits;

  logic                  req_valid;
  logic [15:0]           req_score;
  bcd_t [NUM_DIGITS-1:0] pending;
  logic                  pending_valid;
  bcd_t [NUM_DIGITS-1:0] shown;

  // The converter takes new work when idle or in its DONE cycle; a fresh load beats a queued one.
  assign conv_accept = !conv_busy || conv_done;
  assign conv_start  = conv_accept && (score_load || req_valid);
  assign conv_value  = score_load ? score : req_score;

  bin2bcd_seq u_bin2bcd (
    .clk    (Clk),
    .rst_n  (Reset_n),
    .start  (conv_start),
    .bin_in (conv_value),
    .busy   (conv_busy),
    .done   (conv_done),
    .digits (conv_digits)
  );

  // One-deep request slot for loads arriving mid-conversion; the latest load overwrites.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      req_valid <= 1'b0;
      req_score <= '0;
    end else if (score_load && !conv_accept) begin
      req_valid <= 1'b1;
      req_score <= score;
    end else if (conv_start) begin
      req_valid <= 1'b0;
    end
  end

  // Busy stays up through the cycle after DONE, when the result has just landed in pending.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) busy <= 1'b0;
    else          busy <= conv_start || conv_busy;
  end

  // Double buffer: results park in pending and reach the display only at frame start.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      pending       <= '0;
      pending_valid <= 1'b0;
      shown         <= '0;
    end else if (frame_start && conv_done) begin
      pending       <= conv_digits;
      pending_valid <= 1'b0;
      shown         <= conv_digits;
    end else if (frame_start && pending_valid) begin
      pending_valid <= 1'b0;
      shown         <= pending;
    end else if (conv_done) begin
      pending       <= conv_digits;
      pending_valid <= 1'b1;
    end
  end

  logic [10:0]       px;
  logic [10:0]       py;
  logic [10:0]       col_base;
  logic [10:0]       col_off;
  logic [10:0]       row_off;
  logic [2:0]        col;
  logic              in_field;
  logic              lead_zero;
  logic [NUM_DIGITS-1:0] blank_vec;
  logic [ADDR_W-1:0] pix_addr;

  assign px = {1'b0, DrawX};
  assign py = {1'b0, DrawY};

  // Digit column from constant boundary comparators, so no divide is needed.
  always_comb begin
    col      = 3'd0;
    col_base = X_BASE;
    for (int k = 1; k < NUM_DIGITS; k++) begin
      if (px >= X_BASE + 11'(k * GLYPH_W)) begin
        col      = 3'(k);
        col_base = X_BASE + 11'(k * GLYPH_W);
      end
    end
  end

  // A digit is blank while it and every digit to its left are zero; the units digit always shows.
  always_comb begin
    lead_zero = 1'b1;
    blank_vec = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      lead_zero    = lead_zero && (shown[k] == 4'd0);
      blank_vec[k] = BLANK_LEADING && lead_zero && (k < NUM_DIGITS - 1);
    end
  end

  assign in_field = (px >= X_BASE) && (px < X_END) && (py >= Y_BASE) && (py < Y_END);
  assign col_off  = px - col_base;
  assign row_off  = py - Y_BASE;
  assign pix_addr = glyph_base(shown[col]) + 13'(row_off) * 13'(GLYPH_W) + 13'(col_off);

  logic field_d1;
  logic field_d2;
  logic blank_d1;
  logic blank_d2;
  logic opaque;

  assign opaque = field_d2 && !blank_d2 && (rom_data != KEY_COLOR);

  // Pixel pipeline: address at n+1, ROM data at n+2, colour at n+3; flags ride alongside.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      rom_addr  <= '0;
      field_d1  <= 1'b0;
      field_d2  <= 1'b0;
      blank_d1  <= 1'b0;
      blank_d2  <= 1'b0;
      pixel_on  <= 1'b0;
      pixel_rgb <= '0;
    end else begin
      rom_addr  <= in_field ? pix_addr : '0;
      field_d1  <= in_field;
      blank_d1  <= blank_vec[col];
      field_d2  <= field_d1;
      blank_d2  <= blank_d1;
      pixel_on  <= opaque;
      pixel_rgb <= opaque ? rom_data : '0;
    end
  end

endmodule

// File: tb/tb_score_digit_renderer.sv
// Scoreboard bench for score_digit_renderer with a registered glyph ROM model.
module tb_score_digit_renderer;

  localparam int          X0  = 480;
  localparam int          Y0  = 32;
  localparam logic [23:0] KEY = 24'hFF00FF;

  logic        Clk;
  logic        Reset_n;
  logic [15:0] score;
  logic        score_load;
  logic        frame_start;
  logic [9:0]  DrawX;
  logic [9:0]  DrawY;
  logic [23:0] rom_data;
  logic [12:0] rom_addr;
  logic        busy;
  logic        pixel_on;
  logic [23:0] pixel_rgb;

  score_digit_renderer #(
    .X0            (10'd480),
    .Y0            (10'd32),
    .BLANK_LEADING (1'b1),
    .KEY_COLOR     (24'hFF00FF)
  ) dut (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .score       (score),
    .score_load  (score_load),
    .frame_start (frame_start),
    .DrawX       (DrawX),
    .DrawY       (DrawY),
    .rom_data    (rom_data),
    .rom_addr    (rom_addr),
    .busy        (busy),
    .pixel_on    (pixel_on),
    .pixel_rgb   (pixel_rgb)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  typedef struct { int x; int y; } stim_t;
  typedef struct { int due; logic [12:0] addr; logic on; logic [23:0] rgb; } exp_t;

  stim_t stim_q[$];
  exp_t  addr_q[$];
  exp_t  pix_q[$];
  int    pend_q[$];
  int    exp_shown[5];
  logic [12:0] key_addr    = 13'h1FFF;
  logic [12:0] opaque_addr = 13'h1FFF;
  int    compared   = 0;
  int    mismatched = 0;

  function automatic logic [23:0] rom_fn(input logic [12:0] a);
    if (a == key_addr)    return KEY;
    if (a == opaque_addr) return 24'h112233;
    return {8'h40, 3'b000, a};
  endfunction

  always @(posedge Clk) rom_data <= rom_fn(rom_addr);

  function automatic void set_shown(input int v);
    int r;
    r = v;
    for (int k = 4; k >= 0; k--) begin
      exp_shown[k] = r % 10;
      r = r / 10;
    end
  endfunction

  function automatic void model(input int x, input int y, output logic [12:0] addr,
                                output logic on, output logic [23:0] rgb);
    int  k;
    int  a;
    bit  lead;
    addr = '0;
    on   = 1'b0;
    rgb  = '0;
    if (x >= X0 && x < X0 + 125 && y >= Y0 && y < Y0 + 25) begin
      k    = (x - X0) / 25;
      a    = exp_shown[k] * 625 + (y - Y0) * 25 + (x - X0) % 25;
      addr = 13'(a);
      lead = 1'b1;
      for (int j = 0; j <= k; j++) if (exp_shown[j] != 0) lead = 1'b0;
      rgb  = rom_fn(addr);
      on   = !(lead && k < 4) && (rgb != KEY);
    end
  endfunction

  // Drive queued coordinates one per cycle; expectations are queued at drive time and popped when due.
  task automatic run_stream(input string tag);
    int    t;
    stim_t s;
    exp_t  e;
    exp_t  p;
    t = 0;
    while (stim_q.size() > 0 || addr_q.size() > 0 || pix_q.size() > 0) begin
      if (addr_q.size() > 0 && addr_q[0].due == t) begin
        e = addr_q.pop_front();
        compared++;
        if (rom_addr !== e.addr) begin
          mismatched++;
          $display("FAIL %s rom_addr: got %0d expected %0d", tag, rom_addr, e.addr);
        end
      end
      if (pix_q.size() > 0 && pix_q[0].due == t) begin
        e = pix_q.pop_front();
        compared++;
        if (pixel_on !== e.on) begin
          mismatched++;
          $display("FAIL %s pixel_on: got %0b expected %0b (addr %0d)", tag, pixel_on, e.on, e.addr);
        end
        if (e.on) begin
          compared++;
          if (pixel_rgb !== e.rgb) begin
            mismatched++;
            $display("FAIL %s pixel_rgb: got %h expected %h", tag, pixel_rgb, e.rgb);
          end
        end
      end
      if (stim_q.size() > 0) begin
        s = stim_q.pop_front();
        DrawX = 10'(s.x);
        DrawY = 10'(s.y);
        model(s.x, s.y, p.addr, p.on, p.rgb);
        p.due = t + 1;
        addr_q.push_back(p);
        p.due = t + 3;
        pix_q.push_back(p);
      end else begin
        DrawX = '0;
        DrawY = '0;
      end
      @(negedge Clk);
      t++;
      if (t > 300) begin
        mismatched++;
        $display("FAIL %s stream_timeout: got %0d pending expected 0", tag, addr_q.size() + pix_q.size());
        stim_q.delete();
        addr_q.delete();
        pix_q.delete();
      end
    end
  endtask

  task automatic push(input int x, input int y);
    stim_t s;
    s.x = x;
    s.y = y;
    stim_q.push_back(s);
  endtask

  task automatic render(input string tag);
    for (int k = 0; k < 5; k++) push(X0 + 25 * k + k, Y0 + k * k);
    push(X0 + 124, Y0 + 24);
    push(X0 - 1, Y0 + 3);
    push(X0 + 125, Y0 + 24);
    push(X0 + 5, Y0 - 1);
    push(X0 + 5, Y0 + 25);
    run_stream(tag);
  endtask

  task automatic do_load(input int v);
    score      = 16'(v);
    score_load = 1'b1;
    @(negedge Clk);
    score_load = 1'b0;
  endtask

  task automatic pulse_frame();
    frame_start = 1'b1;
    @(negedge Clk);
    frame_start = 1'b0;
    if (pend_q.size() > 0) set_shown(pend_q.pop_front());
  endtask

  task automatic wait_idle(input string tag, input int limit);
    int n;
    n = 0;
    while (busy === 1'b1 && n < limit) begin
      @(negedge Clk);
      n++;
    end
    compared++;
    if (busy !== 1'b0) begin
      mismatched++;
      $display("FAIL %s busy_timeout: got %b expected 0", tag, busy);
    end
  endtask

  task automatic test_reset();
    @(negedge Clk);
    compared += 4;
    if (rom_addr !== 13'd0) begin mismatched++; $display("FAIL reset rom_addr: got %0d expected 0", rom_addr); end
    if (pixel_on !== 1'b0)  begin mismatched++; $display("FAIL reset pixel_on: got %b expected 0", pixel_on); end
    if (pixel_rgb !== 24'd0) begin mismatched++; $display("FAIL reset pixel_rgb: got %h expected 0", pixel_rgb); end
    if (busy !== 1'b0)      begin mismatched++; $display("FAIL reset busy: got %b expected 0", busy); end
    Reset_n = 1'b1;
    @(negedge Clk);
    for (int k = 0; k < 5; k++) exp_shown[k] = 0;
    push(X0 + 100, Y0 + 12);
    for (int k = 0; k < 4; k++) push(X0 + 25 * k + 7, Y0 + 12);
    run_stream("reset_blank");
  endtask

  task automatic test_convert(input int v, input string tag);
    int n;
    do_load(v);
    pend_q.push_back(v);
    compared++;
    if (busy !== 1'b1) begin mismatched++; $display("FAIL %s busy_rise: got %b expected 1", tag, busy); end
    n = 1;
    while (busy === 1'b1 && n < 40) begin
      @(negedge Clk);
      n++;
    end
    compared++;
    if (n != 19) begin mismatched++; $display("FAIL %s busy_fall_cycle: got %0d expected 19", tag, n); end
    render({tag, "_before_frame"});
    pulse_frame();
    render({tag, "_after_frame"});
  endtask

  task automatic test_key_color();
    key_addr    = 13'd3205;
    opaque_addr = 13'd3385;
    push(X0 + 30, Y0 + 3);
    push(X0 + 60, Y0 + 10);
    push(X0 + 31, Y0 + 3);
    run_stream("key_color");
    key_addr    = 13'h1FFF;
    opaque_addr = 13'h1FFF;
  endtask

  task automatic test_back_to_back();
    do_load(100);
    pend_q.push_back(100);
    @(negedge Clk);
    do_load(200);
    @(negedge Clk);
    do_load(300);
    pend_q.push_back(300);
    repeat (14) @(negedge Clk);
    pulse_frame();
    render("queue_first");
    wait_idle("queue", 60);
    pulse_frame();
    render("queue_latest");
  endtask

  task automatic test_frame_on_done();
    do_load(4321);
    pend_q.push_back(4321);
    repeat (16) @(negedge Clk);
    pulse_frame();
    render("frame_on_done");
    wait_idle("frame_on_done", 10);
  endtask

  task automatic test_reset_mid();
    DrawX = 10'(X0 + 100);
    DrawY = 10'(Y0 + 12);
    do_load(54321);
    @(negedge Clk);
    do_load(777);
    repeat (6) @(negedge Clk);
    #2 Reset_n = 1'b0;
    #1;
    compared += 4;
    if (busy !== 1'b0)       begin mismatched++; $display("FAIL midreset busy: got %b expected 0", busy); end
    if (rom_addr !== 13'd0)  begin mismatched++; $display("FAIL midreset rom_addr: got %0d expected 0", rom_addr); end
    if (pixel_on !== 1'b0)   begin mismatched++; $display("FAIL midreset pixel_on: got %b expected 0", pixel_on); end
    if (pixel_rgb !== 24'd0) begin mismatched++; $display("FAIL midreset pixel_rgb: got %h expected 0", pixel_rgb); end
    @(negedge Clk);
    Reset_n = 1'b1;
    pend_q.delete();
    for (int k = 0; k < 5; k++) exp_shown[k] = 0;
    repeat (3) @(negedge Clk);
    compared++;
    if (busy !== 1'b0) begin mismatched++; $display("FAIL midreset queue_dropped: got busy %b expected 0", busy); end
    render("midreset_zero");
    test_convert(9876, "after_midreset");
  endtask

  initial begin
    Reset_n     = 1'b0;
    score       = '0;
    score_load  = 1'b0;
    frame_start = 1'b0;
    DrawX       = '0;
    DrawY       = '0;
    test_reset();
    test_convert(12345, "conv_12345");
    test_convert(65535, "conv_65535");
    test_key_color();
    test_convert(0, "conv_0");
    test_back_to_back();
    test_frame_on_done();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish before 500us");
    $fatal(1, "watchdog expired");
  end

endmodule
